// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcode constants, the decoded bundle
// layout and the empty-bundle helper used by the decode stage.
package decode_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BRANCHES = 7'b1100011;
    localparam logic [6:0] LOADS    = 7'b0000011;
    localparam logic [6:0] STORES   = 7'b0100011;
    localparam logic [6:0] I_TYPE   = 7'b0010011;
    localparam logic [6:0] R_TYPE   = 7'b0110011;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      shamt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } decoded_t;

    // Bundle shown while the stage is empty: the decode of addi x0,x0,0.
    function automatic decoded_t empty_bundle(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] insn);
        decoded_t d;
        d        = '0;
        d.pc     = pc;
        d.insn   = insn;
        d.opcode = insn[6:0];
        return d;
    endfunction

endpackage

// File: rtl/insn_field_dec.sv
// Combinational RV32I field cracker: register IDs, funct fields, shamt,
// sign-extended immediate and the illegal-encoding flag.
module insn_field_dec
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] insn_i,
    output decoded_t        dec_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;

    assign opc = insn_i[6:0];
    assign f3  = insn_i[14:12];
    assign f7  = insn_i[31:25];

    always_comb begin
        legal = 1'b1;
        case (opc)
            LUI, AUIPC, JAL, SYSTEM: legal = 1'b1;
            JALR:     legal = (f3 == 3'b000);
            BRANCHES: legal = (f3 != 3'b010) && (f3 != 3'b011);
            LOADS:    legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            STORES:   legal = (f3 <= 3'b010);
            R_TYPE:   legal = (f7 == 7'b0000000) ||
                              ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            I_TYPE: begin
                if (f3 == 3'b001)
                    legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    legal = 1'b1;
            end
            default:  legal = 1'b0;
        endcase
        // Compressed/reserved encodings have low bits other than 2'b11.
        if (insn_i[1:0] != 2'b11)
            legal = 1'b0;
    end

    always_comb begin
        dec_o         = '0;
        dec_o.pc      = pc_i;
        dec_o.insn    = insn_i;
        dec_o.opcode  = opc;
        dec_o.rs1     = insn_i[19:15];
        dec_o.funct3  = f3;
        dec_o.shamt   = insn_i[24:20];
        dec_o.illegal = !legal;

        if (opc == R_TYPE || opc == STORES || opc == BRANCHES)
            dec_o.rs2 = insn_i[24:20];
        if (opc == R_TYPE)
            dec_o.funct7 = f7;

        if (legal) begin
            if (opc != STORES && opc != BRANCHES)
                dec_o.rd = insn_i[11:7];
            case (opc)
                I_TYPE, LOADS, JALR, SYSTEM:
                    dec_o.imm = {{20{insn_i[31]}}, insn_i[31:20]};
                STORES:
                    dec_o.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
                BRANCHES:
                    dec_o.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                                 insn_i[30:25], insn_i[11:8], 1'b0};
                LUI, AUIPC:
                    dec_o.imm = {insn_i[31:12], 12'h000};
                JAL:
                    dec_o.imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                                 insn_i[20], insn_i[30:21], 1'b0};
                default:
                    dec_o.imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage: output register plus one skid entry, strict FIFO
// order, full throughput, flush for branch redirect.
module decode_pipe #(
    parameter int                 DWIDTH   = 32,
    parameter int                 AWIDTH   = 32,
    parameter logic [AWIDTH-1:0]  RESET_PC = 32'h0100_0000,
    parameter logic [DWIDTH-1:0]  NOP_INSN = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              illegal_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready, and in_ready_o is a flop.

    localparam decode_pkg::decoded_t EMPTY = decode_pkg::empty_bundle(RESET_PC, NOP_INSN);

    decode_pkg::decoded_t dec;
    decode_pkg::decoded_t out_q, out_d;
    decode_pkg::decoded_t skid_q, skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q;
    logic accept;
    logic out_free;

    insn_field_dec u_dec (
        .pc_i   (pc_i),
        .insn_i (insn_i),
        .dec_o  (dec)
    );

    assign accept   = in_valid_i & in_ready_q;
    assign out_free = !out_valid_q | out_ready_i;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_d        = EMPTY;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept)
                    skid_d = dec;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_d       = EMPTY;
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q        <= EMPTY;
            out_valid_q  <= 1'b0;
            skid_q       <= EMPTY;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign pc_o        = out_q.pc;
    assign insn_o      = out_q.insn;
    assign opcode_o    = out_q.opcode;
    assign rd_o        = out_q.rd;
    assign rs1_o       = out_q.rs1;
    assign rs2_o       = out_q.rs2;
    assign funct3_o    = out_q.funct3;
    assign funct7_o    = out_q.funct7;
    assign shamt_o     = out_q.shamt;
    assign imm_o       = out_q.imm;
    assign illegal_o   = out_q.illegal;

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
Registered, flow-controlled RV32I decode stage with a valid/ready handshake on both sides and a one-entry skid buffer.
- Cracks each accepted instruction into register IDs, funct fields, shamt and a sign-extended immediate.
- Flags illegal encodings.
- Sits between the fetch stage and the register-read/execute stage.
- Provides full-throughput back-pressure tolerance and a pipeline flush for branch redirect.

Parameters:
DWIDTH, 32, instruction/data width (only 32 supported)
AWIDTH, 32, PC width
RESET_PC, 32'h01000000, PC value presented on pc_o while empty/after reset
NOP_INSN, 32'h00000013, instruction presented on insn_o while empty/after reset (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
in_valid_i  in  1  fetch presents an instruction
in_ready_o  out  1  stage can accept (registered)
pc_i  in  AWIDTH  PC of incoming instruction
insn_i  in  DWIDTH  incoming instruction
flush_i  in  1  discard all held instructions
out_valid_o  out  1  decoded bundle valid
out_ready_i  in  1  downstream accepts bundle
pc_o  out  AWIDTH  PC of bundle
insn_o  out  DWIDTH  raw instruction of bundle
opcode_o  out  7  insn[6:0]
rd_o  out  5  destination; 0 for STORES, BRANCHES, illegal
rs1_o  out  5  insn[19:15]
rs2_o  out  5  insn[24:20] for R_TYPE/STORES/BRANCHES, else 0
funct3_o  out  3  insn[14:12]
funct7_o  out  7  insn[31:25] for R_TYPE, else 0
shamt_o  out  5  insn[24:20]
imm_o  out  DWIDTH  sign-extended immediate per format (I/S/B/U/J); 0 for R_TYPE/illegal
illegal_o  out  1  bundle is an illegal encoding

Behaviour:
- Reset (rst=0, async):
  - out_valid_o=0; skid empty; in_ready_o=1 on the first edge after release.
  - pc_o=RESET_PC; insn_o=NOP_INSN.
  - Fields equal decode of NOP: opcode_o=7'h13, all others 0, illegal_o=0.
- Decode is combinational on pc_i/insn_i; results are registered into the output bundle. Latency is 1 cycle from accept (in_valid_i & in_ready_o) to out_valid_o.
- Storage: output register OUT plus one skid entry SKID.
  - in_ready_o = !SKID.valid, registered.
  - Accept with OUT empty or consumed this cycle (out_valid_o & out_ready_i): load OUT.
  - Accept otherwise: load SKID.
  - OUT consumed while SKID valid: SKID moves to OUT. A simultaneous accept lands in SKID in the same cycle.
  - Order is strictly FIFO. Throughput is 1/cycle when out_ready_i=1.
- Holding: while out_valid_o=1 & out_ready_i=0, all outputs are stable.
- Empty: out_valid_o=0 and outputs revert to the NOP/RESET_PC bundle.
- flush_i=1:
  - Next cycle OUT and SKID are invalid; outputs show the NOP bundle; in_ready_o=1.
  - An instruction offered in the flush cycle is dropped.
  - Flush has priority over accept and consume.
- Illegal if any of the following; illegal bundles still flow with rd_o=0, imm_o=0 and raw fields intact:
  - insn[1:0]!=2'b11
  - opcode not in {LUI, AUIPC, JAL, JALR, BRANCHES, LOADS, STORES, I_TYPE, R_TYPE, SYSTEM}
  - JALR funct3!=0
  - BRANCHES funct3 in {010,011}
  - LOADS funct3 in {011,110,111}
  - STORES funct3>010
  - R_TYPE funct7 not in {0000000,0100000}, or funct7=0100000 with funct3 not in {000,101}
  - I_TYPE shift: funct3=001 needs funct7=0; funct3=101 needs funct7 in {0,0100000}
- Immediates use 32-bit arithmetic sign-extended from insn[31]. U-type low 12 bits are 0; B/J bit 0 is 0.

Decomposition:
- Shared package decode_pkg:
  - opcode constants (R_TYPE, I_TYPE, LOADS, STORES, BRANCHES, JAL, JALR, LUI, AUIPC, SYSTEM)
  - decoded_t packed struct (pc, insn, opcode, rd, rs1, rs2, funct3, funct7, shamt, imm, illegal)
  - NOP_INSN default
- One combinational sub-module insn_field_dec (insn, pc -> decoded_t), instantiated once on the input side.
- Skid/output registers stay in decode_pipe.

Test Plan:
- Reset, then offer pc_i=0x01000000, insn_i=0x00A30293 with out_ready_i=1 -> next cycle out_valid_o=1, opcode_o=0x13, rd_o=5, rs1_o=6, rs2_o=0, imm_o=0x0000000A, illegal_o=0.
- insn_i=0xFE712E23 (sw x7,-4(x2)) -> rd_o=0, rs1_o=2, rs2_o=7, funct3_o=2, imm_o=0xFFFFFFFC, funct7_o=0.
- insn_i=0x00002063 (branch funct3=010) -> illegal_o=1, rd_o=0, imm_o=0; insn_i=0x00000000 -> illegal_o=1.
- Back-to-back A, B, C with out_ready_i=0 for 3 cycles -> OUT=A, SKID=B, in_ready_o=0, C held by source. Release out_ready_i -> A, B, C delivered in order on consecutive cycles, none lost or duplicated.
- OUT=A, SKID=B valid, assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, pc_o=0x01000000, insn_o=0x00000013, in_ready_o=1; offered instruction not delivered.
- Drive rst=0 asynchronously mid-stream with OUT and SKID full -> outputs go to the reset bundle immediately without a clock edge. After release, first accepted instruction appears one cycle later.
